// File: rtl/npc_pkg.sv
// npc_pkg: shared sequencer state type, reset PC, XLEN and ebreak encoding.
package npc_pkg;
    localparam int NPC_XLEN = 32;
    localparam logic [31:0] NPC_RESET_PC = 32'h8000_0000;
    localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
    typedef enum logic [3:0] {
        S_FETCH, S_FWAIT, S_DECODE, S_EXEC, S_MEM_REQ, S_MEM_WAIT, S_WB, S_HALT
`ifdef NPC_SEQ_ALIGN_CHECK_EN
        , S_TRAP
`endif
    } npc_state_e;
endpackage

// File: rtl/npc_seq_pc.sv
// npc_seq_pc: PC register with next-PC mux; commits jump target or pc+4 on wen.
module npc_seq_pc #(
    parameter int XLEN = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wen_i,
    input  logic            jump_i,
    input  logic [XLEN-1:0] dnpc_i,
    output logic [XLEN-1:0] pc_o
);
    localparam logic [XLEN-1:0] STEP = 4;
    logic [XLEN-1:0] pc_q, pc_d;
    always_comb pc_d = wen_i ? (jump_i ? dnpc_i : pc_q + STEP) : pc_q;
    always_ff @(posedge clk) pc_q <= rst ? RESET_PC : pc_d;
    assign pc_o = pc_q;
endmodule

// File: rtl/npc_seq.sv
// npc_seq: multi-cycle fetch/decode/exec/mem/wb sequencer owning PC and instret.
// Define NPC_SEQ_ALIGN_CHECK_EN to trap on misaligned jump targets.
module npc_seq
    import npc_pkg::*;
#(
    parameter int XLEN = NPC_XLEN,
    parameter logic [XLEN-1:0] RESET_PC = NPC_RESET_PC,
    parameter int ILEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rsp_valid,
    input  logic [ILEN-1:0] imem_rsp_data,
    output logic [ILEN-1:0] inst,
    output logic            dec_valid,
    input  logic            dec_is_mem,
    input  logic            dec_is_ebreak,
    input  logic            exu_done,
    input  logic            exu_jump,
    input  logic [XLEN-1:0] dnpc,
    output logic            lsu_req_valid,
    input  logic            lsu_req_ready,
    input  logic            lsu_done,
    output logic            reg_wen,
    output logic [XLEN-1:0] pc,
    output logic            retire,
    output logic [XLEN-1:0] instret,
    output logic            halt,
    output logic            trap
);
    localparam logic [XLEN-1:0] ONE = 1;
    npc_state_e state_q, state_d;
    logic [ILEN-1:0] inst_q;
    logic is_mem_q, jump_q;
    logic [XLEN-1:0] dnpc_q, instret_q;
    logic exec_fire;
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:    state_d = imem_req_ready ? S_FWAIT : S_FETCH;
            S_FWAIT:    state_d = imem_rsp_valid ? S_DECODE : S_FWAIT;
            S_DECODE:   state_d = dec_is_ebreak ? S_HALT : S_EXEC;
`ifdef NPC_SEQ_ALIGN_CHECK_EN
            S_EXEC:     state_d = !exu_done ? S_EXEC :
                                  (exu_jump && dnpc[1:0] != 2'b00) ? S_TRAP :
                                  is_mem_q ? S_MEM_REQ : S_WB;
`else
            S_EXEC:     state_d = !exu_done ? S_EXEC : is_mem_q ? S_MEM_REQ : S_WB;
`endif
            S_MEM_REQ:  state_d = !lsu_req_ready ? S_MEM_REQ : lsu_done ? S_WB : S_MEM_WAIT;
            S_MEM_WAIT: state_d = lsu_done ? S_WB : S_MEM_WAIT;
            S_WB:       state_d = S_FETCH;
            default:    state_d = state_q;
        endcase
    end
    assign exec_fire = state_q == S_EXEC && exu_done;
    always_ff @(posedge clk) begin
        state_q   <= rst ? S_FETCH : state_d;
        inst_q    <= rst ? '0 : (state_q == S_FWAIT && imem_rsp_valid) ? imem_rsp_data : inst_q;
        is_mem_q  <= rst ? 1'b0 : state_q == S_DECODE ? dec_is_mem : is_mem_q;
        jump_q    <= rst ? 1'b0 : exec_fire ? exu_jump : jump_q;
        dnpc_q    <= rst ? '0 : exec_fire ? dnpc : dnpc_q;
        instret_q <= rst ? '0 : state_q == S_WB ? instret_q + ONE : instret_q;
    end
    npc_seq_pc #(.XLEN(XLEN), .RESET_PC(RESET_PC)) u_pc (
        .clk    (clk),
        .rst    (rst),
        .wen_i  (state_q == S_WB),
        .jump_i (jump_q),
        .dnpc_i (dnpc_q),
        .pc_o   (pc)
    );
    assign imem_req_valid = state_q == S_FETCH;
    assign imem_addr      = pc;
    assign inst           = inst_q;
    assign dec_valid      = state_q == S_DECODE;
    assign lsu_req_valid  = state_q == S_MEM_REQ;
    assign reg_wen        = state_q == S_WB;
    assign retire         = state_q == S_WB;
    assign instret        = instret_q;
    assign halt           = state_q == S_HALT;
`ifdef NPC_SEQ_ALIGN_CHECK_EN
    assign trap           = state_q == S_TRAP;
`else
    assign trap           = 1'b0;
`endif
endmodule

// File: tb/tb_npc_seq.sv
// tb_npc_seq: directed and randomized instruction streams checked against a PC/instret model.
module tb_npc_seq;
    import npc_pkg::*;
    logic clk = 1'b0, rst = 1'b1;
    logic imem_req_valid, imem_req_ready = 0, imem_rsp_valid = 0;
    logic [31:0] imem_addr, imem_rsp_data = 0, inst, dnpc = 0, pc, instret;
    logic dec_valid, dec_is_mem = 0, dec_is_ebreak = 0, exu_done = 0, exu_jump = 0;
    logic lsu_req_valid, lsu_req_ready = 0, lsu_done = 0, reg_wen, retire, halt, trap;
    int checks = 0, failures = 0;
    int n_wen = 0, n_lreq = 0, n_ret = 0;
    logic [31:0] exp_pc, exp_instret;
    int exp_total = 0;

    always #5 clk = ~clk;

    npc_seq dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data), .inst(inst),
        .dec_valid(dec_valid), .dec_is_mem(dec_is_mem), .dec_is_ebreak(dec_is_ebreak),
        .exu_done(exu_done), .exu_jump(exu_jump), .dnpc(dnpc),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_done(lsu_done),
        .reg_wen(reg_wen), .pc(pc), .retire(retire), .instret(instret), .halt(halt), .trap(trap)
    );

    always @(posedge clk) begin
        if (reg_wen) n_wen <= n_wen + 1;
        if (lsu_req_valid) n_lreq <= n_lreq + 1;
        if (retire) n_ret <= n_ret + 1;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset;
        rst = 1;
        tick;
        rst = 0;
        exp_pc = NPC_RESET_PC;
        exp_instret = 0;
    endtask

    task automatic fetch_phase(input logic [31:0] word, input int d_f, input int d_r);
        check("fetch_valid", imem_req_valid, 1);
        check("fetch_addr", imem_addr, exp_pc);
        for (int i = 0; i < d_f; i++) begin
            imem_rsp_valid = 1'($urandom_range(0, 1));
            imem_rsp_data = $urandom;
            tick;
        end
        imem_rsp_valid = 0;
        imem_req_ready = 1;
        tick;
        imem_req_ready = 0;
        check("fwait_no_req", imem_req_valid, 0);
        for (int i = 0; i < d_r; i++) tick;
        imem_rsp_valid = 1;
        imem_rsp_data = word;
        tick;
        imem_rsp_valid = 0;
        imem_rsp_data = $urandom;
        check("decode_valid", dec_valid, 1);
        check("inst_latched", inst, word);
    endtask

    task automatic decode_exec(input logic [31:0] word, input bit mem, input bit jmp,
                               input logic [31:0] tgt, input int d_e);
        dec_is_mem = mem;
        dec_is_ebreak = (word === INST_EBREAK);
        tick;
        dec_is_mem = 0;
        dec_is_ebreak = 0;
        if (word === INST_EBREAK) return;
        for (int i = 0; i < d_e; i++) begin
            exu_jump = 1'($urandom_range(0, 1));
            dnpc = $urandom;
            tick;
        end
        exu_done = 1;
        exu_jump = jmp;
        dnpc = tgt;
        tick;
        exu_done = 0;
        exu_jump = 0;
        dnpc = $urandom;
    endtask

    task automatic mem_phase(input int d_lr, input int d_ld);
        check("mem_req_valid", lsu_req_valid, 1);
        for (int i = 0; i < d_lr; i++) tick;
        lsu_req_ready = 1;
        lsu_done = (d_ld == 0);
        tick;
        lsu_req_ready = 0;
        lsu_done = 0;
        if (d_ld > 0) begin
            check("mem_wait_no_req", lsu_req_valid, 0);
            for (int i = 0; i < d_ld - 1; i++) tick;
            lsu_done = 1;
            tick;
            lsu_done = 0;
        end
    endtask

    task automatic wb_phase(input bit jmp, input logic [31:0] tgt);
        check("wb_reg_wen", reg_wen, 1);
        check("wb_retire", retire, 1);
        check("wb_pc_hold", pc, exp_pc);
        tick;
        exp_pc = jmp ? tgt : exp_pc + 32'd4;
        exp_instret = exp_instret + 1;
        exp_total++;
        check("post_wb_pc", pc, exp_pc);
        check("post_wb_instret", instret, exp_instret);
        check("post_wb_req", imem_req_valid, 1);
        check("post_wb_retire", retire, 0);
    endtask

    task automatic run_instr(input bit mem, input bit jmp, input logic [31:0] tgt,
                             input int d_f, input int d_r, input int d_e, input int d_lr, input int d_ld);
        logic [31:0] w;
        w = $urandom;
        if (w === INST_EBREAK) w = 32'h0000_0013;
        fetch_phase(w, d_f, d_r);
        decode_exec(w, mem, jmp, tgt, d_e);
        if (mem) mem_phase(d_lr, d_ld);
        wb_phase(jmp, tgt);
    endtask

    initial begin
        int w0, l0;
        exp_pc = NPC_RESET_PC;
        exp_instret = 0;
        tick;
        do_reset;
        check("rst_pc", pc, NPC_RESET_PC);
        check("rst_instret", instret, 0);
        check("rst_inst", inst, 0);
        check("rst_flags", {halt, trap, reg_wen, retire, dec_valid, lsu_req_valid}, 0);
        check("rst_req", imem_req_valid, 1);

        for (int i = 0; i < 3; i++) run_instr(0, 0, 0, 0, 0, 0, 0, 0);
        check("three_pc", pc, 32'h8000_000C);
        check("three_instret", instret, 3);

        run_instr(0, 1, 32'h8000_0100, 0, 0, 0, 0, 0);
        check("jump_addr", imem_addr, 32'h8000_0100);

        w0 = n_wen;
        l0 = n_lreq;
        run_instr(1, 0, 0, 0, 0, 0, 3, 2);
        check("load_req_cycles", n_lreq - l0, 4);
        check("load_wen_pulses", n_wen - w0, 1);

        for (int i = 0; i < 25; i++)
            run_instr(1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0), $urandom & 32'hFFFF_FFFC,
                      $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2),
                      $urandom_range(0, 2), $urandom_range(0, 2));

        fetch_phase(32'h0000_2003, 0, 1);
        decode_exec(32'h0000_2003, 1, 0, 0, 1);
        lsu_req_ready = 1;
        tick;
        lsu_req_ready = 0;
        rst = 1;
        tick;
        rst = 0;
        exp_pc = NPC_RESET_PC;
        exp_instret = 0;
        check("midrst_pc", pc, NPC_RESET_PC);
        check("midrst_instret", instret, 0);
        check("midrst_req", imem_req_valid, 1);
        lsu_done = 1;
        tick;
        lsu_done = 0;
        tick;
        check("late_done_req", imem_req_valid, 1);
        check("late_done_retire", retire, 0);

        fetch_phase(32'h0000_006F, 0, 0);
        decode_exec(32'h0000_006F, 0, 1, 32'h8000_0102, 0);
`ifdef NPC_SEQ_ALIGN_CHECK_EN
        check("trap_set", trap, 1);
        check("trap_pc", pc, NPC_RESET_PC);
        check("trap_retire", retire, 0);
        for (int i = 0; i < 3; i++) tick;
        check("trap_sticky", {trap, imem_req_valid}, 2'b10);
`else
        check("noalign_trap", trap, 0);
        wb_phase(1, 32'h8000_0102);
        check("noalign_pc", pc, 32'h8000_0102);
`endif
        do_reset;

        run_instr(0, 0, 0, 0, 0, 0, 0, 0);
        fetch_phase(INST_EBREAK, 1, 0);
        decode_exec(INST_EBREAK, 0, 0, 0, 0);
        check("halt_set", halt, 1);
        check("halt_instret", instret, exp_instret);
        check("halt_pc", pc, exp_pc);
        check("halt_retire", retire, 0);
        for (int i = 0; i < 5; i++) begin
            imem_req_ready = 1'($urandom_range(0, 1));
            exu_done = 1'($urandom_range(0, 1));
            lsu_done = 1'($urandom_range(0, 1));
            tick;
            check("halt_no_req", {imem_req_valid, halt}, 2'b01);
        end
        imem_req_ready = 0;
        exu_done = 0;
        lsu_done = 0;
        check("total_retires", n_ret, exp_total);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/npc_seq.md
# npc_seq

Multi-cycle instruction sequencer for the NPC core, succeeding the single-cycle PC-increment top. It owns the PC and a stage FSM that drives ifu, idu, exu and lsu through valid/ready handshakes. It commits a taken jump/branch target (`dnpc`) or `pc+4`, counts retired instructions and halts on ebreak. The datapath modules stay outside this block; npc_seq only sequences them.

## Interface
- `XLEN`, 32: PC, dnpc and retire-counter width.
- `RESET_PC`, 32'h80000000: PC value after reset.
- `ILEN`, 32: instruction width.

- `clk`  in  1  core clock; all state changes on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `imem_req_valid`  out  1  fetch request.
- `imem_req_ready`  in  1  fetch request accepted.
- `imem_addr`  out  XLEN  fetch address; equals `pc`.
- `imem_rsp_valid`  in  1  instruction returned.
- `imem_rsp_data`  in  ILEN  instruction word.
- `inst`  out  ILEN  latched instruction, held stable until the next fetch completes.
- `dec_valid`  out  1  one-cycle pulse to idu.
- `dec_is_mem`  in  1  decoded instruction is a load or store; sampled in DECODE.
- `dec_is_ebreak`  in  1  decoded instruction is ebreak; sampled in DECODE.
- `exu_done`  in  1  exu result ready.
- `exu_jump`  in  1  take `dnpc`; sampled with `exu_done`.
- `dnpc`  in  XLEN  jump/branch target; sampled with `exu_done`.
- `lsu_req_valid`  out  1  memory access request.
- `lsu_req_ready`  in  1  lsu accepted the request.
- `lsu_done`  in  1  access complete.
- `reg_wen`  out  1  one-cycle register-file write strobe.
- `pc`  out  XLEN  current PC.
- `retire`  out  1  one-cycle pulse per committed instruction.
- `instret`  out  XLEN  count of retired instructions.
- `halt`  out  1  sticky; set by ebreak.
- `trap`  out  1  sticky; misaligned-target trap (only with `NPC_SEQ_ALIGN_CHECK_EN`).

## Operation
- States: FETCH, FWAIT, DECODE, EXEC, MEM_REQ, MEM_WAIT, WB, HALT, TRAP.
- FETCH: `imem_req_valid`=1. On `imem_req_ready`, go to FWAIT. Any `imem_rsp_valid` seen in FETCH is ignored.
- FWAIT: on `imem_rsp_valid`, latch `inst` and go to DECODE.
- DECODE: one cycle with `dec_valid`=1.
  - `dec_is_ebreak` → HALT. No retire. PC is unchanged.
  - Otherwise latch `dec_is_mem` and go to EXEC.
- EXEC: wait for `exu_done`, then latch `exu_jump` and `dnpc`.
  - If the latched `dec_is_mem` is set → MEM_REQ; otherwise → WB.
- MEM_REQ: `lsu_req_valid`=1 until `lsu_req_ready`, then → MEM_WAIT.
- MEM_WAIT: on `lsu_done` → WB.
  - If `lsu_done` arrives in the same cycle as `lsu_req_ready`, go MEM_REQ → WB directly.
- WB: one cycle with `reg_wen`=1 and `retire`=1.
  - `pc` ← latched jump ? dnpc : pc+4, modulo 2^XLEN.
  - `instret` ← `instret`+1, wrapping to 0 at all-ones.
  - Next state FETCH.
- HALT and TRAP are absorbing: all strobes 0, outputs frozen, left only by `rst`.
- Handshake inputs arriving in a state that does not expect them are ignored.

## Timing
- Reset values:
  - `pc`=RESET_PC, `instret`=0, `inst`=0, state FETCH.
  - `halt`, `trap`, `reg_wen`, `retire`, `dec_valid` and `lsu_req_valid` all 0.
  - `imem_req_valid` is 1 in the first cycle after reset.
- `rst` asserted in any state, including mid-handshake, takes priority: reset values on the next edge, and in-flight responses are dropped.
- Minimum latency, with all responders answering in the cycle after the request:
  - non-memory instruction: 5 cycles (FETCH, FWAIT, DECODE, EXEC, WB);
  - memory instruction: 7 cycles.
- The new `pc` is visible in the cycle after WB, together with the next `imem_req_valid`.
- Outputs are registered or decoded from state only. No combinational path from any input to any output.

## Configuration
- `NPC_SEQ_ALIGN_CHECK_EN` defined: in EXEC, if `exu_jump`=1 and `dnpc[1:0]`≠0, go to TRAP. `trap`=1, `pc` holds the faulting instruction's PC, no retire.
- Undefined: no alignment check. `trap` is tied to 0 and the TRAP state does not exist.

## Structure
- Shared package `npc_pkg` holds:
  - the state enum type;
  - `NPC_RESET_PC`;
  - `NPC_XLEN`;
  - the `INST_EBREAK` encoding (32'h00100073).
- One sub-module, `npc_seq_pc`: the PC register plus next-PC mux, with reset value `RESET_PC` and write enable from WB.

## Test plan
- Reset, then 3 non-jump instructions with single-cycle responders → `pc` steps 0x80000000, 0x80000004, 0x80000008, 0x8000000C; `retire` 3 times, 5 cycles apart; `instret`=3.
- EXEC with `exu_jump`=1, `dnpc`=0x80000100 → `pc`=0x80000100 after WB, and the next `imem_addr`=0x80000100.
- Load with `lsu_req_ready` delayed 3 cycles and `lsu_done` 2 cycles later → `lsu_req_valid` held 4 cycles; a single `reg_wen` pulse.
- `imem_rsp_data`=0x00100073 → `halt`=1 in the cycle after DECODE; `instret` unchanged; no further `imem_req_valid`.
- `rst` asserted during MEM_WAIT → next cycle `pc`=0x80000000, `instret`=0, state FETCH; a late `lsu_done` is ignored.
- With `NPC_SEQ_ALIGN_CHECK_EN`, `dnpc`=0x80000102 with jump → `trap`=1 and `pc` unchanged. Without the macro → `pc`=0x80000102 and `trap`=0.
